// File: rtl/timer_pkg.sv
// Shared types and defaults for the dual countdown timer.
// Holds the channel state enum and the default width and channel-1 divide ratio.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_t;

  localparam int DEF_WIDTH     = 64;
  localparam int DEF_PRESCALE1 = 4;

endpackage

// File: rtl/dual_countdown_timer_if.sv
// Control and status bundle of the dual countdown timer.
// master drives En/Slt/Load/LoadValue/AutoReload; slave drives Count*/Busy*/Expired*.
interface dual_countdown_timer_if #(
  parameter int WIDTH = 64
);

  logic             En;
  logic             Slt;
  logic             Load;
  logic [WIDTH-1:0] LoadValue;
  logic             AutoReload;
  logic [WIDTH-1:0] Count0;
  logic [WIDTH-1:0] Count1;
  logic             Busy0;
  logic             Busy1;
  logic             Expired0;
  logic             Expired1;

  modport master (
    output En, Slt, Load, LoadValue, AutoReload,
    input  Count0, Count1, Busy0, Busy1,
    input  Expired0, Expired1
  );

  modport slave (
    input  En, Slt, Load, LoadValue, AutoReload,
    output Count0, Count1, Busy0, Busy1,
    output Expired0, Expired1
  );

endinterface

// File: rtl/countdown_channel.sv
// One loadable down-counter with optional prescaler and auto-reload.
// Ports: Clk, Reset, Tick, Load, LoadValue, AutoReload in; Count, Busy, Expired out.
module countdown_channel
  import timer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Tick,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             AutoReload,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             Expired
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_mode;
  logic             r_exp;
  logic [PW-1:0]    r_ps;
  chan_state_t      r_state;

  logic w_run;
  logic w_wrap;

  assign w_run  = Tick && (r_state == RUN);
  // With PRESCALE=1 the prescaler is stuck at 0 and wraps every tick.
  assign w_wrap = (r_ps == PW'(PRESCALE - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_count  <= '0;
      r_reload <= '0;
      r_mode   <= 1'b0;
      r_exp    <= 1'b0;
      r_ps     <= '0;
      r_state  <= IDLE;
    end else begin
      r_exp <= 1'b0;
      if (Load) begin
        r_count  <= LoadValue;
        r_reload <= LoadValue;
        r_mode   <= AutoReload;
        r_ps     <= '0;
        r_state  <= (LoadValue != '0) ? RUN : IDLE;
      end else if (w_run) begin
        r_ps <= w_wrap ? '0 : r_ps + PW'(1);
        if (w_wrap) begin
          // In RUN the count is never 0, so not-above-1 means terminal.
          if (r_count > WIDTH'(1)) begin
            r_count <= r_count - WIDTH'(1);
          end else if (r_mode) begin
            r_count <= r_reload;
            r_exp   <= 1'b1;
          end else begin
            r_count <= '0;
            r_state <= IDLE;
            r_exp   <= 1'b1;
          end
        end
      end
    end
  end

  assign Count   = r_count;
  assign Busy    = (r_state == RUN);
  assign Expired = r_exp;

endmodule

// File: rtl/dual_countdown_timer.sv
// Two-channel countdown timer; Slt steers Load and counting to one channel.
// Ports: Clk, Reset plain; everything else through the slave side of bus.
module dual_countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int PRESCALE1 = DEF_PRESCALE1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  dual_countdown_timer_if.slave bus
);

  logic w_ld0;
  logic w_ld1;
  logic w_tk0;
  logic w_tk1;

  assign w_ld0 = bus.Load & ~bus.Slt;
  assign w_ld1 = bus.Load &  bus.Slt;
  // Load wins over a tick in the same cycle.
  assign w_tk0 = bus.En & ~bus.Load & ~bus.Slt;
  assign w_tk1 = bus.En & ~bus.Load &  bus.Slt;

  countdown_channel #(
    .WIDTH    (WIDTH),
    .PRESCALE (1)
  ) u_ch0 (
    .Clk        (Clk),
    .Reset      (Reset),
    .Tick       (w_tk0),
    .Load       (w_ld0),
    .LoadValue  (bus.LoadValue),
    .AutoReload (bus.AutoReload),
    .Count      (bus.Count0),
    .Busy       (bus.Busy0),
    .Expired    (bus.Expired0)
  );

  countdown_channel #(
    .WIDTH    (WIDTH),
    .PRESCALE (PRESCALE1)
  ) u_ch1 (
    .Clk        (Clk),
    .Reset      (Reset),
    .Tick       (w_tk1),
    .Load       (w_ld1),
    .LoadValue  (bus.LoadValue),
    .AutoReload (bus.AutoReload),
    .Count      (bus.Count1),
    .Busy       (bus.Busy1),
    .Expired    (bus.Expired1)
  );

endmodule

// File: tb/tb_dual_countdown_timer.sv
// Self-checking bench for dual_countdown_timer.
// Directed scenarios with constant expectations plus a random run against a model.
module tb_dual_countdown_timer;
  import timer_pkg::*;

  localparam int W  = 64;
  localparam int P1 = 4;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  dual_countdown_timer_if #(.WIDTH(W)) bus ();

  dual_countdown_timer #(
    .WIDTH     (W),
    .PRESCALE1 (P1)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remaining ticks, reload, mode, running, enabled
  // cycles seen since the last decrement, and the pulse flag.
  logic [W-1:0] m_cnt [2];
  logic [W-1:0] m_rld [2];
  bit           m_ar  [2];
  bit           m_run [2];
  bit           m_exp [2];
  int           m_ph  [2];
  int           m_div [2] = '{1, P1};

  task automatic cycle();
    @(posedge Clk);
    for (int c = 0; c < 2; c++) begin
      bit sel;
      sel = (bus.Slt == (c == 1));
      m_exp[c] = 1'b0;
      if (Reset) begin
        m_cnt[c] = '0;
        m_rld[c] = '0;
        m_ar[c]  = 1'b0;
        m_run[c] = 1'b0;
        m_ph[c]  = 0;
      end else if (bus.Load && sel) begin
        m_cnt[c] = bus.LoadValue;
        m_rld[c] = bus.LoadValue;
        m_ar[c]  = bus.AutoReload;
        m_ph[c]  = 0;
        m_run[c] = (bus.LoadValue != 0);
      end else if (bus.En && sel && m_run[c]) begin
        m_ph[c] = m_ph[c] + 1;
        if (m_ph[c] == m_div[c]) begin
          m_ph[c] = 0;
          if (m_cnt[c] > 1) begin
            m_cnt[c] = m_cnt[c] - 1;
          end else begin
            m_exp[c] = 1'b1;
            if (m_ar[c]) begin
              m_cnt[c] = m_rld[c];
            end else begin
              m_cnt[c] = '0;
              m_run[c] = 1'b0;
            end
          end
        end
      end
    end
    @(negedge Clk);
  endtask

  task automatic drive(bit ld, bit slt, bit en, int lv, bit ar);
    bus.Load       = ld;
    bus.Slt        = slt;
    bus.En         = en;
    bus.LoadValue  = W'(lv);
    bus.AutoReload = ar;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    cycle();
    cycle();
    Reset = 1'b0;
    n_cmp++;
    if (bus.Count0 !== '0 || bus.Count1 !== '0 || bus.Busy0 !== 1'b0 ||
        bus.Busy1 !== 1'b0 || bus.Expired0 !== 1'b0 || bus.Expired1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: c0=%0d c1=%0d b=%b%b e=%b%b want all 0",
               bus.Count0, bus.Count1, bus.Busy0, bus.Busy1,
               bus.Expired0, bus.Expired1);
    end
  endtask

  task automatic test_ch0_oneshot();
    drive(1, 0, 1, 3, 0);
    cycle();
    drive(0, 0, 1, 0, 0);
    n_cmp++;
    if (bus.Count0 !== W'(3) || bus.Busy0 !== 1'b1 || bus.Expired0 !== 1'b0) begin
      n_bad++;
      $display("FAIL ch0_load: cnt=%0d busy=%b exp=%b want 3 1 0",
               bus.Count0, bus.Busy0, bus.Expired0);
    end
    for (int k = 1; k <= 4; k++) begin
      logic [W-1:0] wc;
      bit we, wb;
      wc = (k <= 3) ? W'(3 - k) : '0;
      we = (k == 3);
      wb = (k < 3);
      cycle();
      n_cmp++;
      if (bus.Count0 !== wc || bus.Expired0 !== we || bus.Busy0 !== wb ||
          bus.Count1 !== '0) begin
        n_bad++;
        $display("FAIL ch0_oneshot k=%0d: cnt=%0d exp=%b busy=%b c1=%0d want %0d %b %b 0",
                 k, bus.Count0, bus.Expired0, bus.Busy0, bus.Count1, wc, we, wb);
      end
    end
  endtask

  task automatic test_ch1_prescale();
    drive(1, 1, 1, 2, 0);
    cycle();
    drive(0, 1, 1, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      logic [W-1:0] wc;
      bit we;
      wc = (k < 4) ? W'(2) : (k < 8) ? W'(1) : W'(0);
      we = (k == 8);
      cycle();
      n_cmp++;
      if (bus.Count1 !== wc || bus.Expired1 !== we || bus.Busy1 !== (k < 8)) begin
        n_bad++;
        $display("FAIL ch1_prescale k=%0d: cnt=%0d exp=%b busy=%b want %0d %b %b",
                 k, bus.Count1, bus.Expired1, bus.Busy1, wc, we, (k < 8));
      end
    end
  endtask

  task automatic test_autoreload();
    drive(1, 0, 1, 2, 1);
    cycle();
    drive(0, 0, 1, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      logic [W-1:0] wc;
      bit we;
      we = (k % 2 == 0);
      wc = we ? W'(2) : W'(1);
      cycle();
      n_cmp++;
      if (bus.Count0 !== wc || bus.Expired0 !== we || bus.Busy0 !== 1'b1) begin
        n_bad++;
        $display("FAIL autoreload k=%0d: cnt=%0d exp=%b busy=%b want %0d %b 1",
                 k, bus.Count0, bus.Expired0, bus.Busy0, wc, we);
      end
    end
  endtask

  task automatic test_hold();
    drive(1, 1, 1, 5, 0);
    cycle();
    drive(0, 1, 1, 0, 0);
    cycle();
    cycle();
    drive(0, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_cmp++;
      if (bus.Count1 !== W'(5) || bus.Busy1 !== 1'b1) begin
        n_bad++;
        $display("FAIL hold_slt k=%0d: cnt=%0d busy=%b want 5 1",
                 k, bus.Count1, bus.Busy1);
      end
    end
    drive(0, 1, 1, 0, 0);
    cycle();
    n_cmp++;
    if (bus.Count1 !== W'(5)) begin
      n_bad++;
      $display("FAIL resume1: cnt=%0d want 5", bus.Count1);
    end
    cycle();
    n_cmp++;
    if (bus.Count1 !== W'(4)) begin
      n_bad++;
      $display("FAIL resume2: cnt=%0d want 4", bus.Count1);
    end
    cycle();
    cycle();
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_cmp++;
      if (bus.Count1 !== W'(4)) begin
        n_bad++;
        $display("FAIL hold_en k=%0d: cnt=%0d want 4", k, bus.Count1);
      end
    end
    drive(0, 1, 1, 0, 0);
    cycle();
    n_cmp++;
    if (bus.Count1 !== W'(4)) begin
      n_bad++;
      $display("FAIL en_resume1: cnt=%0d want 4", bus.Count1);
    end
    cycle();
    n_cmp++;
    if (bus.Count1 !== W'(3)) begin
      n_bad++;
      $display("FAIL en_resume2: cnt=%0d want 3", bus.Count1);
    end
  endtask

  task automatic test_zero_and_reload();
    drive(1, 0, 1, 0, 0);
    cycle();
    drive(0, 0, 1, 0, 0);
    cycle();
    n_cmp++;
    if (bus.Count0 !== '0 || bus.Busy0 !== 1'b0 || bus.Expired0 !== 1'b0) begin
      n_bad++;
      $display("FAIL load_zero: cnt=%0d busy=%b exp=%b want 0 0 0",
               bus.Count0, bus.Busy0, bus.Expired0);
    end
    drive(1, 1, 1, 1, 0);
    cycle();
    drive(0, 1, 1, 0, 0);
    cycle();
    cycle();
    cycle();
    drive(1, 1, 1, 3, 0);
    cycle();
    drive(0, 1, 1, 0, 0);
    n_cmp++;
    if (bus.Count1 !== W'(3) || bus.Expired1 !== 1'b0 || bus.Busy1 !== 1'b1) begin
      n_bad++;
      $display("FAIL reload_at_one: cnt=%0d exp=%b busy=%b want 3 0 1",
               bus.Count1, bus.Expired1, bus.Busy1);
    end
    cycle();
    cycle();
    cycle();
    n_cmp++;
    if (bus.Count1 !== W'(3)) begin
      n_bad++;
      $display("FAIL ps_cleared3: cnt=%0d want 3", bus.Count1);
    end
    cycle();
    n_cmp++;
    if (bus.Count1 !== W'(2)) begin
      n_bad++;
      $display("FAIL ps_cleared4: cnt=%0d want 2", bus.Count1);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 1, 4, 1);
    cycle();
    drive(0, 0, 1, 0, 0);
    cycle();
    Reset = 1'b1;
    drive(1, 1, 1, 7, 1);
    cycle();
    Reset = 1'b0;
    drive(0, 0, 1, 0, 0);
    n_cmp++;
    if (bus.Count0 !== '0 || bus.Count1 !== '0 || bus.Busy0 !== 1'b0 ||
        bus.Busy1 !== 1'b0 || bus.Expired0 !== 1'b0 || bus.Expired1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: c0=%0d c1=%0d b=%b%b e=%b%b want all 0",
               bus.Count0, bus.Count1, bus.Busy0, bus.Busy1,
               bus.Expired0, bus.Expired1);
    end
    cycle();
    drive(0, 1, 1, 0, 0);
    cycle();
    n_cmp++;
    if (bus.Count0 !== '0 || bus.Count1 !== '0 || bus.Busy0 !== 1'b0 ||
        bus.Busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: c0=%0d c1=%0d b=%b%b want 0 0 00",
               bus.Count0, bus.Count1, bus.Busy0, bus.Busy1);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      Reset = ($urandom_range(0, 99) < 2);
      drive(($urandom_range(0, 99) < 15), 1'($urandom()),
            ($urandom_range(0, 99) < 80), int'($urandom_range(0, 5)),
            1'($urandom()));
      cycle();
      n_cmp++;
      if (bus.Count0 !== m_cnt[0] || bus.Count1 !== m_cnt[1] ||
          bus.Busy0 !== m_run[0] || bus.Busy1 !== m_run[1] ||
          bus.Expired0 !== m_exp[0] || bus.Expired1 !== m_exp[1]) begin
        n_bad++;
        $display("FAIL random k=%0d: c=%0d/%0d b=%b%b e=%b%b want c=%0d/%0d b=%b%b e=%b%b",
                 k, bus.Count0, bus.Count1, bus.Busy0, bus.Busy1,
                 bus.Expired0, bus.Expired1, m_cnt[0], m_cnt[1],
                 m_run[0], m_run[1], m_exp[0], m_exp[1]);
      end
    end
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(negedge Clk);
    test_reset();
    test_ch0_oneshot();
    test_ch1_prescale();
    test_autoreload();
    test_hold();
    test_zero_and_reload();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
